carry_cascade_extender: RTL and testbench

Downstream stage of the 4-bit counter. It consumes the counter's nibble value and its output_carry, and extends the count with UPPER_STAGES further nibbles. It also provides:
- synchronous load of the upper part,
- a one-shot compare-match pulse,
- a sticky overflow flag,
- a one-entry snapshot buffer with a valid/ready handshake for readout.

---
 rtl/counter_pkg.sv | 14 +
 rtl/snapshot_buffer.sv | 53 +++++
 rtl/carry_cascade_extender.sv | 93 +++++++++
 tb/tb_carry_cascade_extender.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the cascaded nibble counter.
package counter_pkg;

  localparam int NIBBLE_WIDTH = 4;

  // Reset is asserted when reset_n equals this level.
  localparam logic RESET_ACTIVE = 1'b0;

  // Full count width: the low nibble plus one nibble per upper stage.
  function automatic int total_width(input int stages);
    return NIBBLE_WIDTH * (stages + 1);
  endfunction

endpackage

// File: rtl/snapshot_buffer.sv
// One-entry capture buffer with valid/ready readout and a dropped-request pulse.
//
// Handshake: a held snapshot is transferred on any rising edge where
// snap_valid=1 and snap_ready=1. A request is captured when the buffer is empty
// or is being emptied on that same edge. Otherwise the request is dropped and
// snap_missed pulses for one cycle. While snap_valid=1, snap_value is held
// stable until the consumer accepts it.
module snapshot_buffer
  import counter_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             snap_request,
  input  logic             snap_ready,
  output logic             snap_valid,
  output logic [WIDTH-1:0] snap_value,
  output logic             snap_missed
);

  logic             r_valid;
  logic [WIDTH-1:0] r_value;
  logic             r_missed;
  logic             w_capture;
  logic             w_drop;

  assign w_capture = snap_request & (~r_valid | snap_ready);
  assign w_drop    = snap_request & r_valid & ~snap_ready;

  // Capture register, valid flag and one-cycle missed pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (reset_n == RESET_ACTIVE) begin
      r_valid  <= 1'b0;
      r_value  <= '0;
      r_missed <= 1'b0;
    end else begin
      if (w_capture) begin
        r_valid <= 1'b1;
        r_value <= i_data;
      end else if (snap_ready) begin
        r_valid <= 1'b0;
      end
      r_missed <= w_drop;
    end
  end

  assign snap_valid  = r_valid;
  assign snap_value  = r_value;
  assign snap_missed = r_missed;

endmodule

// File: rtl/carry_cascade_extender.sv
// Extends a 4-bit low counter with UPPER_STAGES nibbles: loadable upper
// count, sticky overflow, one-shot compare match and a snapshot port.
module carry_cascade_extender
  import counter_pkg::*;
#(
  parameter  int UPPER_STAGES = 2,
  localparam int TOTAL_WIDTH  = total_width(UPPER_STAGES)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    count_enable,
  input  logic [NIBBLE_WIDTH-1:0] low_value,
  input  logic                    low_carry,
  input  logic                    load_enable,
  input  logic [TOTAL_WIDTH-5:0]  load_value,
  input  logic [TOTAL_WIDTH-1:0]  compare_value,
  input  logic                    clear_overflow,
  input  logic                    snap_request,
  input  logic                    snap_ready,
  output logic [TOTAL_WIDTH-1:0]  count_value,
  output logic                    match_pulse,
  output logic                    overflow_flag,
  output logic                    snap_valid,
  output logic [TOTAL_WIDTH-1:0]  snap_value,
  output logic                    snap_missed
);

  localparam int UW = TOTAL_WIDTH - NIBBLE_WIDTH;

  logic [UW-1:0] r_upper;
  logic          r_overflow;
  logic          r_eq_hist;
  logic          r_match;
  logic          w_equal;
  logic          w_wrap;
  logic [TOTAL_WIDTH-1:0] w_count;

  assign w_count = {r_upper, low_value};
  assign w_equal = (w_count == compare_value) & count_enable;
  // The full count wraps only when a carry increments an all-ones upper part.
  assign w_wrap  = low_carry & ~load_enable & (&r_upper);

  // Upper count: load beats carry (the coincident carry is discarded).
  always_ff @(posedge clock or negedge reset_n) begin
    if (reset_n == RESET_ACTIVE) begin
      r_upper <= '0;
    end else if (load_enable) begin
      r_upper <= load_value;
    end else if (low_carry) begin
      r_upper <= r_upper + UW'(1);
    end
  end

  // Sticky overflow; a coincident wrap overrides the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (reset_n == RESET_ACTIVE) begin
      r_overflow <= 1'b0;
    end else if (w_wrap) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Rising-edge detect on the qualified equality gives a one-shot match.
  always_ff @(posedge clock or negedge reset_n) begin
    if (reset_n == RESET_ACTIVE) begin
      r_eq_hist <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_eq_hist <= w_equal;
      r_match   <= w_equal & ~r_eq_hist;
    end
  end

  snapshot_buffer #(
    .WIDTH (TOTAL_WIDTH)
  ) u_snap (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_data       (w_count),
    .snap_request (snap_request),
    .snap_ready   (snap_ready),
    .snap_valid   (snap_valid),
    .snap_value   (snap_value),
    .snap_missed  (snap_missed)
  );

  assign count_value   = w_count;
  assign match_pulse   = r_match;
  assign overflow_flag = r_overflow;

endmodule

// File: tb/tb_carry_cascade_extender.sv
// Directed bench for carry_cascade_extender with UPPER_STAGES=2 (12-bit count).
module tb_carry_cascade_extender;

  localparam int TW = 12;

  logic          clock;
  logic          reset_n;
  logic          count_enable;
  logic [3:0]    low_value;
  logic          low_carry;
  logic          load_enable;
  logic [TW-5:0] load_value;
  logic [TW-1:0] compare_value;
  logic          clear_overflow;
  logic          snap_request;
  logic          snap_ready;
  logic [TW-1:0] count_value;
  logic          match_pulse;
  logic          overflow_flag;
  logic          snap_valid;
  logic [TW-1:0] snap_value;
  logic          snap_missed;

  int checks;
  int failures;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] exp_v;

  carry_cascade_extender #(
    .UPPER_STAGES (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .count_enable   (count_enable),
    .low_value      (low_value),
    .low_carry      (low_carry),
    .load_enable    (load_enable),
    .load_value     (load_value),
    .compare_value  (compare_value),
    .clear_overflow (clear_overflow),
    .snap_request   (snap_request),
    .snap_ready     (snap_ready),
    .count_value    (count_value),
    .match_pulse    (match_pulse),
    .overflow_flag  (overflow_flag),
    .snap_valid     (snap_valid),
    .snap_value     (snap_value),
    .snap_missed    (snap_missed)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Load the upper part in one edge, then release load.
  task automatic load_upper(input logic [TW-5:0] v);
    load_value  = v;
    load_enable = 1'b1;
    tick();
    load_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    count_enable   = 1'b0;
    low_value      = 4'h0;
    low_carry      = 1'b0;
    load_enable    = 1'b0;
    load_value     = '0;
    compare_value  = 12'hFFF;
    clear_overflow = 1'b0;
    snap_request   = 1'b0;
    snap_ready     = 1'b0;
    tick();
    tick();
    checks++;
    if (count_value !== 12'h000) begin
      failures++; $display("FAIL reset_count got=%h exp=000", count_value);
    end
    checks++;
    if ({match_pulse, overflow_flag, snap_valid, snap_missed} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {match_pulse, overflow_flag, snap_valid, snap_missed});
    end
    checks++;
    if (snap_value !== 12'h000) begin
      failures++; $display("FAIL reset_snap_value got=%h exp=000", snap_value);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  // Model the low 4-bit counter: carry is high in the cycle it wraps 15->0.
  task automatic test_count40();
    logic [3:0] lo;
    lo = 4'h0;
    low_value = lo;
    count_enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      low_carry = (lo == 4'hF);
      tick();
      lo = lo + 4'h1;
      low_value = lo;
    end
    low_carry = 1'b0;
    count_enable = 1'b0;
    #1;
    checks++;
    if (count_value !== 12'h028) begin
      failures++; $display("FAIL count40 got=%h exp=028", count_value);
    end
    checks++;
    if (overflow_flag !== 1'b0) begin
      failures++; $display("FAIL count40_overflow got=%b exp=0", overflow_flag);
    end
  endtask

  task automatic test_load_vs_carry();
    load_upper(8'h00);
    low_value   = 4'hF;
    low_carry   = 1'b1;
    load_value  = 8'hA5;
    load_enable = 1'b1;
    tick();
    load_enable = 1'b0;
    low_carry   = 1'b0;
    low_value   = 4'h7;
    #1;
    checks++;
    if (count_value !== 12'hA57) begin
      failures++; $display("FAIL load_vs_carry got=%h exp=A57", count_value);
    end
    checks++;
    if (overflow_flag !== 1'b0) begin
      failures++; $display("FAIL load_vs_carry_overflow got=%b exp=0", overflow_flag);
    end
  endtask

  task automatic test_overflow();
    load_upper(8'hFF);
    low_value = 4'hF;
    low_carry = 1'b1;
    tick();
    low_carry = 1'b0;
    low_value = 4'h0;
    #1;
    checks++;
    if (count_value !== 12'h000) begin
      failures++; $display("FAIL wrap_count got=%h exp=000", count_value);
    end
    checks++;
    if (overflow_flag !== 1'b1) begin
      failures++; $display("FAIL wrap_set got=%b exp=1", overflow_flag);
    end
    tick(); tick(); tick();
    checks++;
    if (overflow_flag !== 1'b1) begin
      failures++; $display("FAIL wrap_sticky got=%b exp=1", overflow_flag);
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++;
    if (overflow_flag !== 1'b0) begin
      failures++; $display("FAIL clear got=%b exp=0", overflow_flag);
    end
    // A load onto an all-ones upper part with a carry must not set the flag.
    load_upper(8'hFF);
    low_value   = 4'hF;
    low_carry   = 1'b1;
    load_value  = 8'hFF;
    load_enable = 1'b1;
    tick();
    load_enable = 1'b0;
    low_carry   = 1'b0;
    checks++;
    if (overflow_flag !== 1'b0 || count_value !== 12'hFFF) begin
      failures++;
      $display("FAIL load_no_overflow got=%b/%h exp=0/FFF", overflow_flag, count_value);
    end
    // Clear coincident with a new wrap: the set wins.
    low_carry      = 1'b1;
    clear_overflow = 1'b1;
    tick();
    low_carry      = 1'b0;
    clear_overflow = 1'b0;
    low_value      = 4'h0;
    #1;
    checks++;
    if (overflow_flag !== 1'b1) begin
      failures++; $display("FAIL clear_vs_wrap got=%b exp=1", overflow_flag);
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
  endtask

  task automatic test_match();
    int pulses;
    int first_idx;
    count_enable  = 1'b0;
    compare_value = 12'h123;
    low_value     = 4'h3;
    load_upper(8'h12);
    tick();
    checks++;
    if (match_pulse !== 1'b0) begin
      failures++; $display("FAIL match_disabled got=%b exp=0", match_pulse);
    end
    count_enable = 1'b1;
    pulses = 0;
    first_idx = -1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (match_pulse === 1'b1) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    checks++;
    if (pulses != 1 || first_idx != 0) begin
      failures++;
      $display("FAIL match_once got=%0d pulses at %0d exp=1 pulse at 0", pulses, first_idx);
    end
    count_enable = 1'b0;
    tick();
    count_enable = 1'b1;
    tick();
    checks++;
    if (match_pulse !== 1'b1) begin
      failures++; $display("FAIL match_retrigger got=%b exp=1", match_pulse);
    end
    tick();
    checks++;
    if (match_pulse !== 1'b0) begin
      failures++; $display("FAIL match_retrigger_end got=%b exp=0", match_pulse);
    end
    count_enable  = 1'b0;
    compare_value = 12'hFFF;
  endtask

  task automatic test_snapshot();
    low_value = 4'h0;
    load_upper(8'h05);
    snap_ready   = 1'b0;
    snap_request = 1'b1;
    exp_q.push_back(12'h050);
    tick();
    snap_request = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (snap_valid !== 1'b1 || snap_value !== exp_v) begin
      failures++;
      $display("FAIL snap_capture got=%b/%h exp=1/%h", snap_valid, snap_value, exp_v);
    end
    tick();
    low_value = 4'h8;
    tick();
    snap_request = 1'b1;
    tick();
    snap_request = 1'b0;
    checks++;
    if (snap_missed !== 1'b1 || snap_value !== exp_v || snap_valid !== 1'b1) begin
      failures++;
      $display("FAIL snap_drop got=%b/%h/%b exp=1/%h/1", snap_missed, snap_value, snap_valid, exp_v);
    end
    tick();
    checks++;
    if (snap_missed !== 1'b0) begin
      failures++; $display("FAIL snap_missed_pulse got=%b exp=0", snap_missed);
    end
    low_value = 4'h0;
    load_upper(8'h06);
    snap_ready   = 1'b1;
    snap_request = 1'b1;
    exp_q.push_back(12'h060);
    tick();
    snap_request = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (snap_valid !== 1'b1 || snap_value !== exp_v || snap_missed !== 1'b0) begin
      failures++;
      $display("FAIL snap_accept_capture got=%b/%h/%b exp=1/%h/0", snap_valid, snap_value, snap_missed, exp_v);
    end
    tick();
    snap_ready = 1'b0;
    checks++;
    if (snap_valid !== 1'b0 || snap_value !== exp_v) begin
      failures++;
      $display("FAIL snap_accept got=%b/%h exp=0/%h", snap_valid, snap_value, exp_v);
    end
  endtask

  task automatic test_async_reset();
    load_upper(8'hFF);
    low_value = 4'hF;
    low_carry = 1'b1;
    tick();
    low_carry = 1'b0;
    low_value = 4'h0;
    snap_request = 1'b1;
    tick();
    snap_request = 1'b0;
    checks++;
    if (snap_valid !== 1'b1 || overflow_flag !== 1'b1) begin
      failures++; $display("FAIL pre_reset got=%b/%b exp=1/1", snap_valid, overflow_flag);
    end
    low_value = 4'h9;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({match_pulse, overflow_flag, snap_valid, snap_missed} !== 4'b0000 || snap_value !== 12'h000) begin
      failures++;
      $display("FAIL async_reset got=%b/%h exp=0000/000",
               {match_pulse, overflow_flag, snap_valid, snap_missed}, snap_value);
    end
    checks++;
    if (count_value !== 12'h009) begin
      failures++; $display("FAIL async_reset_count got=%h exp=009", count_value);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++;
    if (snap_valid !== 1'b0 || snap_missed !== 1'b0) begin
      failures++; $display("FAIL post_reset got=%b/%b exp=0/0", snap_valid, snap_missed);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_count40();
    test_load_vs_carry();
    test_overflow();
    test_match();
    test_snapshot();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
